bit_deframer: RTL and testbench

//  Downstream of the BPSK signal demodulator. Consumes one hard bit per symbol:

---
 rtl/bit_deframer.sv | 138 +++++++++++++
 tb/tb_bit_deframer.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/bit_deframer.sv
// bit_deframer: sync-word hunt with BPSK polarity resolution, MSB-first byte packing, byte FIFO out
//   clk, rst            clock, asynchronous active-high reset
//   enable              receiver armed; low forces HUNT and drops any partial byte
//   bit_in, bit_valid   demodulated hard bit and its one-cycle strobe
//   byte_out/valid/ready FIFO head byte, non-empty flag, consumer accept
//   locked              high while packing payload
//   inverted            inverse sync seen; payload bits are flipped
//   frame_done          one-cycle pulse after the last payload byte of a frame is pushed
//   overflow            sticky: a byte was dropped because the FIFO was full
module bit_deframer #(
    parameter int                    SYNC_WIDTH = 8,
    parameter logic [SYNC_WIDTH-1:0] SYNC_WORD  = 8'hD5,
    parameter int                    FRAME_LEN  = 4,
    parameter int                    FIFO_DEPTH = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       enable,
    input  logic       bit_in,
    input  logic       bit_valid,
    output logic [7:0] byte_out,
    output logic       byte_valid,
    input  logic       byte_ready,
    output logic       locked,
    output logic       inverted,
    output logic       frame_done,
    output logic       overflow
);
    localparam int FW = $clog2(SYNC_WIDTH + 1);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;

    typedef enum logic {HUNT, PAYLOAD} state_t;

    state_t                state, state_n;
    logic [SYNC_WIDTH-1:0] sh, sh_n, sh_shift;
    logic [FW-1:0]         fill, fill_n;
    logic                  inv_n;
    logic [6:0]            bsr, bsr_n;
    logic [2:0]            bit_cnt, bit_cnt_n;
    logic [7:0]            byte_cnt, byte_cnt_n;
    logic                  push, last;
    logic [7:0]            push_data;
    logic [7:0]            mem [FIFO_DEPTH];
    logic [PW-1:0]         wr_ptr, rd_ptr;
    logic [CW-1:0]         count;
    logic                  full, pop, wr_ok;

    assign sh_shift  = {sh[SYNC_WIDTH-2:0], bit_in};
    assign push_data = {bsr, bit_in ^ inverted};
    assign locked    = state == PAYLOAD;

    always_comb begin
        state_n    = state;
        sh_n       = sh;
        fill_n     = fill;
        inv_n      = inverted;
        bsr_n      = bsr;
        bit_cnt_n  = bit_cnt;
        byte_cnt_n = byte_cnt;
        push       = 1'b0;
        last       = 1'b0;
        if (!enable) begin
            state_n    = HUNT;
            fill_n     = '0;
            bit_cnt_n  = '0;
            byte_cnt_n = '0;
        end else if (bit_valid) begin
            if (state == HUNT) begin
                sh_n   = sh_shift;
                fill_n = (fill == FW'(SYNC_WIDTH)) ? fill : fill + FW'(1);
                // the bit being taken counts toward the fill, hence SYNC_WIDTH-1
                if (fill >= FW'(SYNC_WIDTH - 1) && (sh_shift == SYNC_WORD || sh_shift == ~SYNC_WORD)) begin
                    state_n    = PAYLOAD;
                    inv_n      = sh_shift != SYNC_WORD;
                    bit_cnt_n  = '0;
                    byte_cnt_n = '0;
                end
            end else begin
                bsr_n     = push_data[6:0];
                bit_cnt_n = bit_cnt + 3'd1;
                if (bit_cnt == 3'd7) begin
                    push       = 1'b1;
                    byte_cnt_n = byte_cnt + 8'd1;
                    if (byte_cnt == 8'(FRAME_LEN - 1)) begin
                        last       = 1'b1;
                        state_n    = HUNT;
                        fill_n     = '0;
                        sh_n       = '0;
                        byte_cnt_n = '0;
                    end
                end
            end
        end
    end

    // a pop frees the head slot on the same edge, so a full FIFO still takes the push
    assign byte_valid = count != '0;
    assign pop        = byte_valid && byte_ready;
    assign full       = count == CW'(FIFO_DEPTH);
    assign wr_ok      = push && (!full || pop);
    assign byte_out   = byte_valid ? mem[rd_ptr] : 8'h00;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= HUNT;
            sh         <= '0;
            fill       <= '0;
            inverted   <= 1'b0;
            bsr        <= '0;
            bit_cnt    <= '0;
            byte_cnt   <= '0;
            frame_done <= 1'b0;
            overflow   <= 1'b0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
        end else begin
            state      <= state_n;
            sh         <= sh_n;
            fill       <= fill_n;
            inverted   <= inv_n;
            bsr        <= bsr_n;
            bit_cnt    <= bit_cnt_n;
            byte_cnt   <= byte_cnt_n;
            frame_done <= last;
            overflow   <= overflow | (push && !wr_ok);
            wr_ptr     <= wr_ok ? wr_ptr + PW'(1) : wr_ptr;
            rd_ptr     <= pop ? rd_ptr + PW'(1) : rd_ptr;
            count      <= count + CW'(wr_ok) - CW'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (wr_ok)
            mem[wr_ptr] <= push_data;
    end
endmodule

// File: tb/tb_bit_deframer.sv
// tb_bit_deframer: scoreboard bench for bit_deframer (lock, inversion, false sync, backpressure, abort)
module tb_bit_deframer;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       enable = 1'b1;
    logic       bit_in = 1'b0;
    logic       bit_valid = 1'b0;
    logic [7:0] byte_out;
    logic       byte_valid;
    logic       byte_ready = 1'b0;
    logic       locked, inverted, frame_done, overflow;

    int         checks = 0;
    int         errors = 0;
    logic [7:0] exp_q[$];
    logic [7:0] e;

    bit_deframer dut (
        .clk(clk), .rst(rst), .enable(enable), .bit_in(bit_in), .bit_valid(bit_valid),
        .byte_out(byte_out), .byte_valid(byte_valid), .byte_ready(byte_ready),
        .locked(locked), .inverted(inverted), .frame_done(frame_done), .overflow(overflow)
    );

    always #5 clk = ~clk;

    // scoreboard: every byte the consumer takes must be the next expected one
    always @(negedge clk) begin
        if (!rst && byte_valid && byte_ready) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL pop_unexpected: got %h, expected no byte", byte_out);
            end else begin
                e = exp_q.pop_front();
                if (byte_out !== e) begin
                    errors++;
                    $display("FAIL pop_data: got %h, expected %h", byte_out, e);
                end
            end
        end
    end

    task automatic send_bit(input logic b);
        bit_in    = b;
        bit_valid = 1'b1;
        @(posedge clk);
        #1;
        bit_valid = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] v);
        for (int i = 7; i >= 0; i--) send_bit(v[i]);
    endtask

    task automatic do_reset();
        rst = 1'b1; enable = 1'b1; bit_valid = 1'b0; byte_ready = 1'b0;
        exp_q.delete();
        @(posedge clk); @(posedge clk); #1;
        rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if ({byte_out, byte_valid, locked, inverted, frame_done, overflow} !== 13'h0) begin
            errors++;
            $display("FAIL reset_outputs: got %h, expected 0", {byte_out, byte_valid, locked, inverted, frame_done, overflow});
        end
    endtask

    task automatic test_lock();
        logic [7:0] sync = 8'hD5;
        logic [7:0] pl[4] = '{8'h3C, 8'hA5, 8'h00, 8'hFF};
        byte_ready = 1'b1;
        for (int i = 7; i >= 1; i--) send_bit(sync[i]);
        checks++;
        if (locked !== 1'b0) begin errors++; $display("FAIL lock_early: locked=%b expected 0", locked); end
        send_bit(sync[0]);
        checks++;
        if (locked !== 1'b1 || inverted !== 1'b0) begin
            errors++; $display("FAIL lock_sync: locked=%b inverted=%b expected 1 0", locked, inverted);
        end
        for (int k = 0; k < 4; k++) begin
            exp_q.push_back(pl[k]);
            send_byte(pl[k]);
            if (k == 0) begin
                checks++;
                if (byte_valid !== 1'b1 || byte_out !== 8'h3C) begin
                    errors++; $display("FAIL lock_first_byte: valid=%b byte=%h expected 1 3c", byte_valid, byte_out);
                end
            end
        end
        checks++;
        if (frame_done !== 1'b1 || locked !== 1'b0) begin
            errors++; $display("FAIL lock_frame_done: done=%b locked=%b expected 1 0", frame_done, locked);
        end
        @(posedge clk); #1;
        checks++;
        if (frame_done !== 1'b0) begin errors++; $display("FAIL lock_done_pulse: done=%b expected 0", frame_done); end
        repeat (10) @(posedge clk);
        #1;
        checks++;
        if (exp_q.size() != 0 || byte_valid !== 1'b0) begin
            errors++; $display("FAIL lock_drain: left=%0d valid=%b expected 0 0", exp_q.size(), byte_valid);
        end
    endtask

    task automatic test_inverted();
        logic [7:0] pl[4] = '{8'h3C, 8'hA5, 8'h00, 8'hFF};
        byte_ready = 1'b1;
        send_byte(8'h2A);
        checks++;
        if (locked !== 1'b1 || inverted !== 1'b1) begin
            errors++; $display("FAIL inv_lock: locked=%b inverted=%b expected 1 1", locked, inverted);
        end
        for (int k = 0; k < 4; k++) begin
            exp_q.push_back(pl[k]);
            send_byte(~pl[k]);
        end
        repeat (10) @(posedge clk);
        #1;
        checks++;
        if (exp_q.size() != 0 || locked !== 1'b0 || inverted !== 1'b1) begin
            errors++;
            $display("FAIL inv_after: left=%0d locked=%b inverted=%b expected 0 0 1", exp_q.size(), locked, inverted);
        end
    endtask

    task automatic test_false_sync();
        // only the window ending at the last bit is D5; at bit 7 the register reads 2A with a partial fill
        logic [22:0] seq = 23'b0101010_1101010_0_11010101;
        do_reset();
        for (int i = 22; i >= 0; i--) begin
            send_bit(seq[i]);
            checks++;
            if (locked !== (i == 0)) begin
                errors++; $display("FAIL false_sync_bit%0d: locked=%b expected %b", 23 - i, locked, i == 0);
            end
        end
        checks++;
        if (inverted !== 1'b0) begin errors++; $display("FAIL false_sync_pol: inverted=%b expected 0", inverted); end
        enable = 1'b0;
        @(posedge clk); #1;
        enable = 1'b1;
    endtask

    task automatic test_backpressure();
        logic [7:0] pl[4] = '{8'h3C, 8'hA5, 8'h00, 8'hFF};
        logic [7:0] dr[4] = '{8'h11, 8'h22, 8'h33, 8'h44};
        do_reset();
        send_byte(8'hD5);
        for (int k = 0; k < 4; k++) begin
            exp_q.push_back(pl[k]);
            send_byte(pl[k]);
        end
        checks++;
        if (byte_valid !== 1'b1 || overflow !== 1'b0) begin
            errors++; $display("FAIL bp_full: valid=%b overflow=%b expected 1 0", byte_valid, overflow);
        end
        send_byte(8'hD5);
        for (int k = 0; k < 4; k++) send_byte(dr[k]);
        checks++;
        if (overflow !== 1'b1 || frame_done !== 1'b1) begin
            errors++; $display("FAIL bp_overflow: overflow=%b done=%b expected 1 1", overflow, frame_done);
        end
        byte_ready = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        checks++;
        if (exp_q.size() != 0 || byte_valid !== 1'b0 || overflow !== 1'b1) begin
            errors++;
            $display("FAIL bp_drain: left=%0d valid=%b overflow=%b expected 0 0 1", exp_q.size(), byte_valid, overflow);
        end
    endtask

    task automatic test_full_push_pop();
        logic [7:0] pl[4] = '{8'h3C, 8'hA5, 8'h00, 8'hFF};
        logic [7:0] nb = 8'h5A;
        logic [7:0] tl[3] = '{8'h77, 8'h88, 8'h99};
        do_reset();
        send_byte(8'hD5);
        for (int k = 0; k < 4; k++) begin
            exp_q.push_back(pl[k]);
            send_byte(pl[k]);
        end
        send_byte(8'hD5);
        exp_q.push_back(nb);
        for (int i = 7; i >= 1; i--) send_bit(nb[i]);
        byte_ready = 1'b1;
        send_bit(nb[0]);
        byte_ready = 1'b0;
        checks++;
        if (overflow !== 1'b0 || byte_valid !== 1'b1 || byte_out !== 8'hA5) begin
            errors++;
            $display("FAIL fpp_edge: overflow=%b valid=%b head=%h expected 0 1 a5", overflow, byte_valid, byte_out);
        end
        byte_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            exp_q.push_back(tl[k]);
            send_byte(tl[k]);
        end
        repeat (10) @(posedge clk);
        #1;
        checks++;
        if (exp_q.size() != 0 || overflow !== 1'b0) begin
            errors++; $display("FAIL fpp_drain: left=%0d overflow=%b expected 0 0", exp_q.size(), overflow);
        end
    endtask

    task automatic test_abort();
        do_reset();
        send_byte(8'hD5);
        exp_q.push_back(8'h3C); send_byte(8'h3C);
        exp_q.push_back(8'hA5); send_byte(8'hA5);
        send_bit(1'b1); send_bit(1'b1); send_bit(1'b1);
        enable = 1'b0; bit_in = 1'b1; bit_valid = 1'b1;
        @(posedge clk); #1;
        bit_valid = 1'b0;
        checks++;
        if (locked !== 1'b0 || byte_valid !== 1'b1) begin
            errors++; $display("FAIL abort_state: locked=%b valid=%b expected 0 1", locked, byte_valid);
        end
        enable = 1'b1;
        byte_ready = 1'b1;
        repeat (6) @(posedge clk);
        #1;
        checks++;
        if (exp_q.size() != 0 || byte_valid !== 1'b0) begin
            errors++; $display("FAIL abort_drain: left=%0d valid=%b expected 0 0", exp_q.size(), byte_valid);
        end
        byte_ready = 1'b0;
        send_byte(8'h2A);
        send_byte(8'hC3);
        send_bit(1'b1); send_bit(1'b0); send_bit(1'b1); send_bit(1'b0);
        checks++;
        if (locked !== 1'b1 || inverted !== 1'b1 || byte_valid !== 1'b1) begin
            errors++; $display("FAIL abort_prerst: locked=%b inv=%b valid=%b expected 1 1 1", locked, inverted, byte_valid);
        end
        rst = 1'b1;
        #1;
        checks++;
        if ({byte_out, byte_valid, locked, inverted, frame_done, overflow} !== 13'h0) begin
            errors++;
            $display("FAIL abort_rst: got %h, expected 0", {byte_out, byte_valid, locked, inverted, frame_done, overflow});
        end
        exp_q.delete();
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    initial begin
        test_reset();
        test_lock();
        test_inverted();
        test_false_sync();
        test_backpressure();
        test_full_push_pop();
        test_abort();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
